sum_bcd_converter: RTL

- Sequential binary-to-BCD converter that sits directly downstream of the 17-bit ripple adder.
- Takes the adder's 18-bit sum and converts it to six BCD digits for the seven-segment HEX displays.
- Uses an iterative shift-add-3 (double-dabble) method, one bit per clock, instead of a large combinational divider.
- Valid/ready input handshake, one-cycle done pulse, registered results held until the next conversion completes.

---
 rtl/sum_bcd_converter.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/sum_bcd_converter.sv
// -----------------------------------------------------------------------------
// sum_bcd_converter
//
// Sequential binary-to-BCD converter placed after the 17-bit ripple adder.
// It turns the adder's unsigned sum (including carry-out) into packed BCD
// digits for the seven-segment HEX displays. It uses shift-add-3
// (double-dabble), one binary bit per clock, so no wide divider is needed.
//
// Ports
//   clk        system clock, all state changes on the rising edge
//   reset      synchronous, active-high; overrides everything, even mid-run
//   in_valid   sum_in carries an operand this cycle
//   in_ready   converter is idle and will take an operand on this edge
//   sum_in     unsigned binary sum, IN_WIDTH bits
//   busy       conversion in progress (shifting or presenting the result)
//   done       one-cycle pulse; bcd_out / digit_nz hold a fresh result
//   bcd_out    packed BCD, digit i at bits [4i+3:4i], digit 0 = ones
//   digit_nz   leading-zero blanking mask. Bit i is set when digit i or any
//              higher digit is nonzero. Bit 0 is always set.
//   state_dbg  raw FSM state, for debug and checker binding
//
// Handshake: an operand transfers on a rising edge where in_valid and
// in_ready are both 1. in_ready is 1 only in IDLE. While in_ready is 0,
// in_valid is ignored and nothing is queued, so the producer must hold or
// resend. With in_valid held high, operands are taken every IN_WIDTH + 2
// cycles.
//
// Timing for an accept on edge k:
//   - Edges k+1 .. k+IN_WIDTH each shift one bit.
//   - The last of these edges loads bcd_out / digit_nz and enters DONE.
//   - Edge k+IN_WIDTH+1 returns to IDLE.
//   - bcd_out / digit_nz change only on that final shift edge or on reset.
// -----------------------------------------------------------------------------
module sum_bcd_converter #(
    parameter int IN_WIDTH = 18,
    // DIGITS must satisfy 10**DIGITS > 2**IN_WIDTH - 1 so the result never
    // overflows the scratch register.
    parameter int DIGITS   = 6
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IN_WIDTH-1:0]   sum_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [DIGITS-1:0]     digit_nz,
    output logic [1:0]            state_dbg
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);

    // The counter value seen during the final shift edge.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    // Working registers.
    logic [IN_WIDTH-1:0] bin_q;      // remaining binary bits, MSB first
    logic [BCD_W-1:0]    scratch_q;  // BCD digits built so far
    logic [CNT_W-1:0]    cnt_q;      // shift edges taken so far

    // Result registers, held between conversions.
    logic [BCD_W-1:0]    bcd_q;
    logic [DIGITS-1:0]   nz_q;

    // Combinational helpers.
    logic                          accept;
    logic                          last_shift;
    logic [BCD_W-1:0]              adjusted;
    logic [BCD_W+IN_WIDTH-1:0]     shift_pair;
    logic [BCD_W-1:0]              scratch_next;
    logic [IN_WIDTH-1:0]           bin_next;
    logic [DIGITS-1:0]             nz_next;
    logic                          nz_seen;

    // -------------------------------------------------------------------------
    // Control decode
    // -------------------------------------------------------------------------
    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign last_shift = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);

    // -------------------------------------------------------------------------
    // Double-dabble step
    // -------------------------------------------------------------------------

    // Add 3 to any digit of 5 or more before shifting. After the doubling,
    // such a digit then carries into the next digit instead of passing 9.
    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5) begin
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Shift {scratch, binary} left as one vector, so the binary MSB drops
    // into scratch bit 0. Bits shifted out of the top digit are always zero
    // for legal DIGITS.
    assign shift_pair   = {adjusted, bin_q} << 1;
    assign scratch_next = shift_pair[BCD_W+IN_WIDTH-1:IN_WIDTH];
    assign bin_next     = shift_pair[IN_WIDTH-1:0];

    // Build the blanking mask from the value about to be loaded. Scan from the
    // most significant digit down; once a nonzero digit is found, that digit
    // and every lower one stay lit.
    always_comb begin
        nz_seen = 1'b0;
        nz_next = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_seen    = nz_seen | (scratch_next[4*i +: 4] != 4'd0);
            nz_next[i] = nz_seen;
        end
        // The ones digit is always shown, so zero displays as "0".
        nz_next[0] = 1'b1;
    end

    // -------------------------------------------------------------------------
    // FSM state register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // FSM next state and outputs. Outputs are decoded from the registered
    // state only, so they are glitch-free.
    // -------------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (last_shift) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Datapath
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            bin_q     <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            nz_q      <= DIGITS'(1);
        end else if (accept) begin
            bin_q     <= sum_in;
            scratch_q <= '0;
            cnt_q     <= '0;
        end else if (state_q == ST_SHIFT) begin
            bin_q     <= bin_next;
            scratch_q <= scratch_next;
            cnt_q     <= cnt_q + 1'b1;
            // Load the results only on the final shift edge, so the previous
            // result stays visible for the whole of a conversion.
            if (last_shift) begin
                bcd_q <= scratch_next;
                nz_q  <= nz_next;
            end
        end
    end

    assign bcd_out   = bcd_q;
    assign digit_nz  = nz_q;
    assign state_dbg = state_q;

endmodule
